// File: rtl/mo3_detector.sv
// Serial multiple-of-3 detector: tracks the stream value mod 3, MSB first.
// out is decoded from the remainder register only.
module mo3_detector (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   typedef enum logic [1:0] {
      R0 = 2'b00,
      R1 = 2'b01,
      R2 = 2'b10
   } state_e;

   state_e state_q;
   state_e state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= R0;
      end else begin
         state_q <= state_d;
      end
   end

   // r_next = (2*r + in) mod 3; the unused code falls back to R0
   always_comb begin
      state_d = R0;
      case (state_q)
         R0:      state_d = in ? R1 : R0;
         R1:      state_d = in ? R0 : R2;
         R2:      state_d = in ? R2 : R1;
         default: state_d = R0;
      endcase
   end

   assign out = (state_q == R0);

endmodule

// File: tb/tb_mo3_detector.sv
// Directed bench for mo3_detector.
// Inputs change 1ns after rising edges; out is checked at the same point.
module tb_mo3_detector;

   logic clk;
   logic reset;
   logic in;
   logic out;

   int checks;
   int errors;

   mo3_detector dut (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs,
                        input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic b,
                       input logic exp);
      in = b;
      @(posedge clk);
      #1;
      check(tag, out, exp);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in    = 1'b0;
      @(posedge clk);
      #1;
      check("reset_out", out, 1'b1);
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      in     = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_start", out, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // 1: leading zeros then 1011101 (93), then trailing zeros
      do_reset();
      step("t1_b0", 1'b0, 1'b1);
      step("t1_b1", 1'b0, 1'b1);
      step("t1_b2", 1'b0, 1'b1);
      step("t1_b3", 1'b1, 1'b0);
      step("t1_b4", 1'b0, 1'b0);
      step("t1_b5", 1'b1, 1'b0);
      step("t1_b6", 1'b1, 1'b0);
      step("t1_b7", 1'b1, 1'b0);
      step("t1_b8", 1'b0, 1'b0);
      step("t1_b9", 1'b1, 1'b1);
      step("t1_b10", 1'b0, 1'b1);
      step("t1_b11", 1'b0, 1'b1);
      step("t1_b12", 1'b0, 1'b1);

      // 2: values 1,3,7,15,31
      do_reset();
      step("t2_b0", 1'b1, 1'b0);
      step("t2_b1", 1'b1, 1'b1);
      step("t2_b2", 1'b1, 1'b0);
      step("t2_b3", 1'b1, 1'b1);
      step("t2_b4", 1'b1, 1'b0);

      // 3: all zeros stay in R0
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step($sformatf("t3_b%0d", i), 1'b0, 1'b1);
      end

      // 4: value 2
      do_reset();
      step("t4_b0", 1'b0, 1'b1);
      step("t4_b1", 1'b0, 1'b1);
      step("t4_b2", 1'b0, 1'b1);
      step("t4_b3", 1'b1, 1'b0);
      step("t4_b4", 1'b0, 1'b0);

      // 5: async reset while in R2, no clock edge involved
      do_reset();
      step("t5_b0", 1'b1, 1'b0);
      step("t5_b1", 1'b0, 1'b0);
      #1;
      reset = 1'b0;
      #1;
      check("t5_async_out", out, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("t5_after_release", out, 1'b1);
      step("t5_n0", 1'b1, 1'b0);
      step("t5_n1", 1'b1, 1'b1);
      step("t5_n2", 1'b1, 1'b0);

      // 6: reset held across edges with in toggling
      step("t6_pre", 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("t6_hold%0d", i), 1'(i % 2 == 0), 1'b1);
      end
      reset = 1'b1;
      step("t6_r0", 1'b1, 1'b0);
      step("t6_r1", 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
